// File: rtl/peripheral_gpio_debounce.sv
// rtl/peripheral_gpio_debounce.sv - pad synchroniser and per-bit debouncer ahead of the GPIO peripheral
module peripheral_gpio_debounce #(
  parameter int PDATA_SIZE  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  enable,
  input  logic [CNT_WIDTH-1:0]  debounce_limit,
  input  logic [PDATA_SIZE-1:0] pad_i,
  output logic [PDATA_SIZE-1:0] gpio_i,
  output logic [PDATA_SIZE-1:0] rise_o,
  output logic [PDATA_SIZE-1:0] fall_o,
  output logic                  event_o
);

  logic [SYNC_STAGES-1:0][PDATA_SIZE-1:0] sync_q;
  logic [PDATA_SIZE-1:0][CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PDATA_SIZE-1:0]                  gpio_q, gpio_d;
  logic [PDATA_SIZE-1:0]                  rise_q, rise_d;
  logic [PDATA_SIZE-1:0]                  fall_q, fall_d;
  logic                                   event_q, event_d;
  logic [PDATA_SIZE-1:0]                  sync_s;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // ">=" lets a lowered limit take effect immediately instead of wrapping the count
  always_comb begin
    cnt_d  = '0;
    gpio_d = gpio_q;
    rise_d = '0;
    fall_d = '0;
    if (enable) begin
      for (int b = 0; b < PDATA_SIZE; b++) begin
        if (sync_s[b] == gpio_q[b]) begin
          cnt_d[b] = '0;
        end else if (cnt_q[b] >= debounce_limit) begin
          gpio_d[b] = sync_s[b];
          rise_d[b] = sync_s[b];
          fall_d[b] = ~sync_s[b];
          cnt_d[b]  = '0;
        end else begin
          cnt_d[b] = cnt_q[b] + CNT_WIDTH'(1);
        end
      end
    end
    event_d = |(rise_d | fall_d);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      gpio_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pad_i};
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign gpio_i  = gpio_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule

// File: tb/tb_peripheral_gpio_debounce.sv
// tb/tb_peripheral_gpio_debounce.sv - directed self-checking bench for peripheral_gpio_debounce
module tb_peripheral_gpio_debounce;

  logic       PCLK;
  logic       PRESET;
  logic       enable;
  logic [7:0] debounce_limit;
  logic [7:0] pad_i;
  logic [7:0] gpio_i;
  logic [7:0] rise_o;
  logic [7:0] fall_o;
  logic       event_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] acc_rise, acc_fall, acc_ovl;
  logic       acc_evt, acc_evbad;
  int         n_rise0;

  peripheral_gpio_debounce #(
    .PDATA_SIZE (8),
    .SYNC_STAGES(2),
    .CNT_WIDTH  (8)
  ) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .enable        (enable),
    .debounce_limit(debounce_limit),
    .pad_i         (pad_i),
    .gpio_i        (gpio_i),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .event_o       (event_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic acc_clear();
    acc_rise  = '0;
    acc_fall  = '0;
    acc_ovl   = '0;
    acc_evt   = 1'b0;
    acc_evbad = 1'b0;
    n_rise0   = 0;
  endtask

  // advance n rising edges, sampling 1 time unit after each edge
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK);
      #1;
      acc_rise  |= rise_o;
      acc_fall  |= fall_o;
      acc_ovl   |= rise_o & fall_o;
      acc_evt   |= event_o;
      acc_evbad |= (event_o !== |(rise_o | fall_o));
      if (rise_o[0]) n_rise0++;
    end
  endtask

  task automatic do_reset();
    pad_i  = 8'h00;
    PRESET = 1'b1;
    run(2);
    PRESET = 1'b0;
    run(3);
    acc_clear();
  endtask

  initial begin
    PRESET         = 1'b1;
    enable         = 1'b1;
    debounce_limit = 8'd3;
    pad_i          = 8'h00;
    acc_clear();
    #2;
    check("reset_gpio", gpio_i, 8'h00);
    check("reset_pulses", {rise_o, fall_o}, 16'h0000);
    check("reset_event", event_o, 1'b0);

    // L=3 step: update on the 6th edge
    run(2);
    PRESET = 1'b0;
    run(2);
    pad_i = 8'h01;
    run(5);
    check("l3_gpio_e5", gpio_i, 8'h00);
    check("l3_rise_e5", rise_o, 8'h00);
    run(1);
    check("l3_gpio_e6", gpio_i, 8'h01);
    check("l3_rise_e6", rise_o, 8'h01);
    check("l3_event_e6", event_o, 1'b1);
    run(1);
    check("l3_rise_e7", rise_o, 8'h00);
    check("l3_event_e7", event_o, 1'b0);
    check("l3_gpio_e7", gpio_i, 8'h01);

    // L=4 glitch of 3 cycles is rejected
    do_reset();
    debounce_limit = 8'd4;
    pad_i = 8'h04;
    run(3);
    pad_i = 8'h00;
    run(10);
    check("glitch_gpio", gpio_i, 8'h00);
    check("glitch_pulses", {acc_rise, acc_fall}, 16'h0000);
    pad_i = 8'h04;
    run(6);
    check("l4_rise_e6", rise_o, 8'h00);
    run(1);
    check("l4_rise_e7", rise_o, 8'h04);
    check("l4_gpio_e7", gpio_i, 8'h04);
    run(3);

    // L=0 full-bus toggle
    do_reset();
    debounce_limit = 8'd0;
    pad_i = 8'hFF;
    run(2);
    check("l0_rise_e2", rise_o, 8'h00);
    run(1);
    check("l0_rise_e3", rise_o, 8'hFF);
    check("l0_gpio_e3", gpio_i, 8'hFF);
    check("l0_fall_e3", fall_o, 8'h00);
    run(17);
    pad_i = 8'h00;
    run(2);
    check("l0_fall_e2", fall_o, 8'h00);
    check("l0_gpio_hold", gpio_i, 8'hFF);
    run(1);
    check("l0_fall_e3b", fall_o, 8'hFF);
    check("l0_rise_e3b", rise_o, 8'h00);
    check("l0_gpio_low", gpio_i, 8'h00);
    run(5);
    check("l0_overlap", acc_ovl, 8'h00);
    check("l0_event_agree", acc_evbad, 1'b0);

    // lowering L mid-count updates on the next edge without wrapping
    do_reset();
    debounce_limit = 8'd200;
    pad_i = 8'h01;
    run(50);
    check("l200_no_rise", acc_rise, 8'h00);
    debounce_limit = 8'd10;
    run(1);
    check("lower_rise", rise_o, 8'h01);
    check("lower_gpio", gpio_i, 8'h01);
    run(20);
    check("lower_single_pulse", n_rise0, 1);
    check("lower_gpio_stays", gpio_i, 8'h01);

    // enable=0 freezes state; re-enable with L=2
    do_reset();
    enable = 1'b0;
    pad_i  = 8'hA5;
    run(30);
    check("dis_gpio", gpio_i, 8'h00);
    check("dis_pulses", {acc_rise, acc_fall}, 16'h0000);
    check("dis_event", acc_evt, 1'b0);
    debounce_limit = 8'd2;
    enable = 1'b1;
    run(2);
    check("en_gpio_e2", gpio_i, 8'h00);
    run(1);
    check("en_gpio_e3", gpio_i, 8'hA5);
    check("en_rise_e3", rise_o, 8'hA5);
    check("en_event_e3", event_o, 1'b1);

    // asynchronous reset mid-count
    do_reset();
    debounce_limit = 8'd0;
    pad_i = 8'hF0;
    run(4);
    check("pre_gpio", gpio_i, 8'hF0);
    debounce_limit = 8'd5;
    pad_i = 8'h0F;
    run(5);
    check("mid_gpio", gpio_i, 8'hF0);
    #2;
    PRESET = 1'b1;
    #1;
    check("async_gpio", gpio_i, 8'h00);
    check("async_pulses", {rise_o, fall_o}, 16'h0000);
    check("async_event", event_o, 1'b0);
    pad_i = 8'h00;
    acc_clear();
    run(2);
    PRESET = 1'b0;
    run(15);
    check("abort_pulses", {acc_rise, acc_fall}, 16'h0000);
    check("abort_gpio", gpio_i, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
